// File: rtl/node_gen2.sv
// node_gen2: NoC endpoint that queues host packets, serialises them into flits toward a router, and reassembles inbound flits into a receive queue.
// Ports:
//   clock, reset             : single clock, synchronous active-high reset
//   pkt_in, pkt_in_avail     : host packet write into the DEPTH-entry transmit FIFO
//   cQ_full, cQ_count        : transmit FIFO status
//   pkt_out, pkt_out_avail,
//   pkt_out_ready            : head of the OUT_DEPTH-entry receive queue, valid/ready drain
//   free_outbound, put_outbound,
//   payload_outbound         : outbound flit link, MSB flit first
//   free_inbound, put_inbound,
//   payload_inbound          : inbound flit link, gaps allowed inside a packet
//   protocol_err             : sticky, a packet-start flit arrived while not permitted
module node_gen2 #(
  parameter int PKT_W     = 32,
  parameter int FLIT_W    = 8,
  parameter int DEPTH     = 4,
  parameter int OUT_DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [PKT_W-1:0]             pkt_in,
  input  logic                         pkt_in_avail,
  output logic                         cQ_full,
  output logic [$clog2(DEPTH+1)-1:0]   cQ_count,
  output logic [PKT_W-1:0]             pkt_out,
  output logic                         pkt_out_avail,
  input  logic                         pkt_out_ready,
  input  logic                         free_outbound,
  output logic                         put_outbound,
  output logic [FLIT_W-1:0]            payload_outbound,
  output logic                         free_inbound,
  input  logic                         put_inbound,
  input  logic [FLIT_W-1:0]            payload_inbound,
  output logic                         protocol_err
);
  localparam int N  = PKT_W / FLIT_W;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(N);
  localparam int RW = $clog2(OUT_DEPTH + 1);
  localparam int AW = PKT_W - FLIT_W;
  if (PKT_W % FLIT_W != 0 || PKT_W / FLIT_W < 2) begin : g_bad_width
    $error("node_gen2: PKT_W must be a multiple of FLIT_W with at least two flits");
  end
  if (DEPTH < 1 || OUT_DEPTH < 1) begin : g_bad_depth
    $error("node_gen2: DEPTH and OUT_DEPTH must be at least 1");
  end
  typedef enum logic {IDLE, SEND} tx_state_t;
  tx_state_t        state;
  logic [PKT_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PKT_W-1:0] sr;
  logic [NW-1:0]    c;
  logic             push, pop;
  assign cQ_full = cQ_count == CW'(DEPTH);
  assign push    = pkt_in_avail && !cQ_full;
  // put_outbound still high means the last flit just left; holding off one
  // cycle guarantees the idle gap between consecutive packets.
  assign pop     = state == IDLE && !put_outbound && cQ_count != '0 && free_outbound;
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= pkt_in;
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      cQ_count         <= '0;
      state            <= IDLE;
      sr               <= '0;
      c                <= '0;
      put_outbound     <= 1'b0;
      payload_outbound <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == PW'(DEPTH-1) ? '0 : wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr == PW'(DEPTH-1) ? '0 : rd_ptr + PW'(1);
      cQ_count <= cQ_count + CW'(push) - CW'(pop);
      if (state == SEND) begin
        payload_outbound <= sr[PKT_W-1 -: FLIT_W];
        sr               <= sr << FLIT_W;
        c                <= c + NW'(1);
        if (c == NW'(N-1)) begin
          state <= IDLE;
          c     <= '0;
        end
      end else if (pop) begin
        payload_outbound <= mem[rd_ptr][PKT_W-1 -: FLIT_W];
        sr               <= mem[rd_ptr] << FLIT_W;
        put_outbound     <= 1'b1;
        c                <= NW'(1);
        state            <= SEND;
      end else begin
        put_outbound <= 1'b0;
      end
    end
  end
  logic [AW-1:0]    shreg;
  logic [NW-1:0]    rx_cnt, rx_cnt_n;
  logic [RW-1:0]    rx_count, rx_count_n, widx;
  logic [PKT_W-1:0] q [OUT_DEPTH];
  logic             bad, acc, done, rpop;
  assign pkt_out = q[0];
  always_comb begin
    bad        = put_inbound && rx_cnt == '0 && !free_inbound;
    acc        = put_inbound && !bad;
    done       = acc && rx_cnt == NW'(N-1);
    rpop       = pkt_out_avail && pkt_out_ready;
    rx_cnt_n   = done ? '0 : acc ? rx_cnt + NW'(1) : rx_cnt;
    rx_count_n = rx_count + RW'(done) - RW'(rpop);
    widx       = rx_count - RW'(rpop);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_cnt        <= '0;
      rx_count      <= '0;
      shreg         <= '0;
      free_inbound  <= 1'b1;
      protocol_err  <= 1'b0;
      pkt_out_avail <= 1'b0;
    end else begin
      rx_cnt        <= rx_cnt_n;
      rx_count      <= rx_count_n;
      if (acc) shreg <= AW'({shreg, payload_inbound});
      if (bad) protocol_err <= 1'b1;
      free_inbound  <= rx_cnt_n == '0 && rx_count_n < RW'(OUT_DEPTH);
      pkt_out_avail <= rx_count_n != '0;
    end
  end
  // Receive queue is a shift array so the head is always a plain register.
  for (genvar i = 0; i < OUT_DEPTH; i++) begin : g_q
    logic [PKT_W-1:0] above;
    if (i < OUT_DEPTH - 1) begin : g_mid
      assign above = q[i+1];
    end else begin : g_tail
      assign above = '0;
    end
    always_ff @(posedge clock)
      if (reset) q[i] <= '0;
      else if (done && widx == RW'(i)) q[i] <= {shreg, payload_inbound};
      else if (rpop) q[i] <= above;
  end
endmodule

// File: doc/node_gen2.md
# node_gen2

Parametrised NoC endpoint between the testbench/host and one router port. Queues host packets in a DEPTH-entry transmit FIFO and serialises each packet MSB-first into PKT_W/FLIT_W flits toward the router under router back-pressure. Reassembles inbound flits into packets and holds them in an OUT_DEPTH-entry receive queue drained by a valid/ready handshake. Flits of an inbound packet may arrive with gaps, and receive protocol violations are reported.

## Interface
- PKT_W, 32, packet width in bits; PKT_W % FLIT_W == 0 and N = PKT_W/FLIT_W ≥ 2, otherwise elaboration error
- FLIT_W, 8, flit width on the router link
- DEPTH, 4, transmit FIFO entries (≥1, any integer)
- OUT_DEPTH, 2, receive queue entries (≥1)
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- pkt_in  in  PKT_W  host packet; [PKT_W-1 -: FLIT_W] is the header {src,dest}
- pkt_in_avail  in  1  write request for pkt_in
- cQ_full  out  1  transmit FIFO full (count == DEPTH)
- cQ_count  out  $clog2(DEPTH+1)  transmit FIFO occupancy
- pkt_out  out  PKT_W  head of receive queue, valid when pkt_out_avail
- pkt_out_avail  out  1  receive queue non-empty
- pkt_out_ready  in  1  host accepts pkt_out this cycle
- free_outbound  in  1  router can accept a whole packet
- put_outbound  out  1  flit valid on payload_outbound
- payload_outbound  out  FLIT_W  outbound flit
- free_inbound  out  1  node can accept a new packet
- put_inbound  in  1  flit valid on payload_inbound
- payload_inbound  in  FLIT_W  inbound flit
- protocol_err  out  1  sticky: inbound flit arrived while a new packet was not permitted

## Operation
- Reset values: cQ_full=0, cQ_count=0, pkt_out_avail=0, pkt_out=0, put_outbound=0, payload_outbound=0, free_inbound=1, protocol_err=0. Reset asserted mid-packet discards all queued, partially sent and partially assembled data; put_outbound is 0 from the first reset edge.
- TX FIFO write: taken at the edge when pkt_in_avail && !cQ_full. Full is evaluated from pre-edge state, so a write while full is dropped even if a pop happens at the same edge. A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged. Pointers wrap DEPTH-1 → 0.
- TX FSM has two states, IDLE and SEND, plus flit counter c (0..N-1).
  - IDLE: when FIFO is non-empty and free_outbound=1 at the edge: pop head into the shift register, drive put_outbound=1 and payload_outbound=slice 0 (MSB), set c=1, go to SEND. Otherwise put_outbound=0.
  - SEND: each edge drives slice c, c++. After slice N-1 is driven, return to IDLE. free_outbound is ignored during SEND.
- RX assembly: each put_inbound=1 flit shifts into the assembly register MSB-first and increments rx_cnt.
  - The flit that makes rx_cnt reach N pushes {assembly, flit} into the receive queue at the same edge, then rx_cnt=0.
  - Gaps (put_inbound=0) mid-packet are allowed; assembly state is held.
- A first flit (rx_cnt==0) arriving while free_inbound==0 is dropped and sets protocol_err=1 until reset.
- RX queue: pop when pkt_out_avail && pkt_out_ready. Push and pop may occur at the same edge.
- free_inbound (registered) next value = (rx_cnt_next == 0) && (rx_count_next < OUT_DEPTH).

## Timing
- Host-to-link latency: pkt_in_avail sampled at edge k into an empty FIFO with free_outbound=1 → put_outbound=1 after edge k+1.
- put_outbound stays high exactly N consecutive cycles per packet. There is at least one idle cycle between packets because IDLE is re-entered.
- Link-to-host latency: last flit sampled at edge e → pkt_out_avail=1 and pkt_out valid after edge e.
- free_inbound drops after the edge that samples the first flit. It rises after the edge that completes the packet only if the queue still has space.
- pkt_out and pkt_out_avail are driven from registers only; no combinational path from pkt_out_ready.

## Test plan
- Defaults; reset, then write 0xA1B2C3D4 with free_outbound=1 → put_outbound high 4 cycles with flits A1, B2, C3, D4; cQ_count returns to 0.
- Write 5 packets on consecutive cycles with free_outbound=0 → cQ_full=1 after the 4th; 5th dropped; cQ_count=4; after free_outbound=1, exactly 4 packets emitted in order with 1-cycle gaps.
- Inbound flits 12,34,_,56,78 (gap cycle) with pkt_out_ready=0 → pkt_out=0x12345678 with pkt_out_avail=1 one edge after flit 78; free_inbound=1 afterwards.
- Two inbound packets with pkt_out_ready=0 → free_inbound=0 after the 2nd completes; a new flit then sets protocol_err=1 and the queue is unchanged; pulse ready → free_inbound returns to 1.
- PKT_W=64, FLIT_W=16, DEPTH=3 → 4-flit bursts; pointer wraparound after 7 packets; FIFO order preserved.
- Assert reset during flit 2 of SEND and during RX assembly → put_outbound=0, cQ_count=0, free_inbound=1, pkt_out_avail=0 after that edge.
